// File: rtl/result_checker.sv
// In-order result checker: FIFO of expected values compared against arriving DUT results.
// Optional first-fail capture ports are built when CHK_FIRST_FAIL_CAPTURE_EN is defined.
module result_checker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    exp_valid_i,
    input  logic [DATA_W-1:0]       exp_data_i,
    output logic                    exp_ready_o,
    input  logic                    dut_valid_i,
    input  logic [DATA_W-1:0]       dut_data_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    compare_o,
    output logic                    correct_o,
    output logic [CNT_W-1:0]        pass_cnt_o,
    output logic [CNT_W-1:0]        fail_cnt_o,
    output logic                    error_o,
    output logic                    overflow_o,
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    output logic [DATA_W-1:0]       first_fail_exp_o,
    output logic [DATA_W-1:0]       first_fail_got_o,
    output logic [CNT_W-1:0]        first_fail_idx_o,
`endif
    output logic                    underflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] head;
    logic              vld_p0;
    logic              match_p0;
    logic              udf_p0;
    logic              vld_p1;
    logic              match_p1;
    logic              udf_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: FIFO state and combinational compare against the head entry
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    assign pop      = dut_valid_i && !empty;
    assign udf_p0   = dut_valid_i && empty;
    assign push     = exp_valid_i && (!full || pop);
    assign drop     = exp_valid_i && full && !pop;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign vld_p0   = dut_valid_i;
    // Case equality so an X/Z bit on the DUT side reads as a mismatch in simulation.
    assign match_p0 = pop && (dut_data_i === head);

    assign level_o     = level;
    assign exp_ready_o = !full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clear_i) mem[wr_ptr[AW-1:0]] <= exp_data_i;
    end

    // Stage p1: registered compare outcome
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1   <= 1'b0;
            match_p1 <= 1'b0;
            udf_p1   <= 1'b0;
        end else if (clear_i) begin
            vld_p1   <= 1'b0;
            match_p1 <= 1'b0;
            udf_p1   <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            match_p1 <= match_p0;
            udf_p1   <= udf_p0;
        end
    end

    // Stage p2: statistics and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            compare_o   <= 1'b0;
            correct_o   <= 1'b0;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            error_o     <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clear_i) begin
            compare_o   <= 1'b0;
            correct_o   <= 1'b0;
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            error_o     <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            compare_o <= vld_p1;
            if (vld_p1) begin
                correct_o <= match_p1;
                if (match_p1) begin
                    pass_cnt_o <= sat_inc(pass_cnt_o);
                end else begin
                    fail_cnt_o <= sat_inc(fail_cnt_o);
                    error_o    <= 1'b1;
                end
            end
            if (udf_p1) underflow_o <= 1'b1;
        end
    end

`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    logic [DATA_W-1:0] exp_p1;
    logic [DATA_W-1:0] got_p1;
    logic [CNT_W-1:0]  idx;

    assign idx = pass_cnt_o + fail_cnt_o;

    always_ff @(posedge clk_i) begin
        exp_p1 <= pop ? head : '0;
        got_p1 <= dut_data_i;
    end

    // error_o doubles as the "first fail already seen" marker.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_fail_exp_o <= '0;
            first_fail_got_o <= '0;
            first_fail_idx_o <= '0;
        end else if (clear_i) begin
            first_fail_exp_o <= '0;
            first_fail_got_o <= '0;
            first_fail_idx_o <= '0;
        end else if (vld_p1 && !match_p1 && !error_o) begin
            first_fail_exp_o <= exp_p1;
            first_fail_got_o <= got_p1;
            first_fail_idx_o <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker (DEPTH=8, CNT_W=4); expected compare outcomes are queued
// at issue time and a negedge monitor checks them whenever compare_o pulses.
module tb_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_data = '0;
    logic        exp_ready;
    logic        dut_valid = 1'b0;
    logic [15:0] dut_data = '0;
    logic [3:0]  level;
    logic        compare;
    logic        correct;
    logic [3:0]  pass_cnt;
    logic [3:0]  fail_cnt;
    logic        error;
    logic        overflow;
    logic        underflow;
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
    logic [15:0] ff_exp;
    logic [15:0] ff_got;
    logic [3:0]  ff_idx;
`endif

    result_checker #(.DATA_W(16), .DEPTH(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .exp_valid_i(exp_valid), .exp_data_i(exp_data), .exp_ready_o(exp_ready),
        .dut_valid_i(dut_valid), .dut_data_i(dut_data), .level_o(level),
        .compare_o(compare), .correct_o(correct),
        .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt),
        .error_o(error), .overflow_o(overflow),
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        .first_fail_exp_o(ff_exp), .first_fail_got_o(ff_got), .first_fail_idx_o(ff_idx),
`endif
        .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ok;
        int   pass;
        int   fail;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_cmp = 0;
    int   n_issued = 0;
    int   m_pass = 0;
    int   m_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Monitor: pops one expectation per compare_o pulse.
    always @(negedge clk) begin
        if (!rst && compare) begin
            exp_t e;
            n_cmp++;
            if (sb.size() == 0) begin
                check("unexpected_compare", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("correct", {31'd0, correct}, {31'd0, e.ok});
                check("pass_cnt", {28'd0, pass_cnt}, e.pass);
                check("fail_cnt", {28'd0, fail_cnt}, e.fail);
            end
        end
    end

    task automatic expect_cmp(input logic ok);
        exp_t e;
        if (ok) m_pass = (m_pass == 15) ? 15 : m_pass + 1;
        else    m_fail = (m_fail == 15) ? 15 : m_fail + 1;
        e.ok = ok;
        e.pass = m_pass;
        e.fail = m_fail;
        sb.push_back(e);
        n_issued++;
    endtask

    task automatic do_push(input logic [15:0] v);
        exp_valid = 1'b1;
        exp_data = v;
        @(posedge clk); #1;
        exp_valid = 1'b0;
    endtask

    task automatic do_dut(input logic [15:0] v, input logic ok);
        dut_valid = 1'b1;
        dut_data = v;
        expect_cmp(ok);
        @(posedge clk); #1;
        dut_valid = 1'b0;
    endtask

    task automatic do_push_pop(input logic [15:0] pv, input logic [15:0] dv, input logic ok);
        exp_valid = 1'b1;
        exp_data = pv;
        dut_valid = 1'b1;
        dut_data = dv;
        expect_cmp(ok);
        @(posedge clk); #1;
        exp_valid = 1'b0;
        dut_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_pass = 0;
        m_fail = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        check("drain_timeout", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_ready", {31'd0, exp_ready}, 32'd1);
        check("rst_outputs", {23'd0, compare, correct, pass_cnt, fail_cnt, error, overflow, underflow},
              32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Matched stream
        do_push(16'd5);
        do_push(16'd9);
        do_push(16'hFFFF);
        check("push3_level", {28'd0, level}, 32'd3);
        do_dut(16'd5, 1'b1);
        do_dut(16'd9, 1'b1);
        do_dut(16'hFFFF, 1'b1);
        wait_drain();
        check("match_cmps", n_cmp, 32'd3);
        check("match_error", {31'd0, error}, 32'd0);
        check("match_level", {28'd0, level}, 32'd0);
        do_clear();

        // Mismatch
        do_push(16'h1234);
        do_dut(16'h1235, 1'b0);
        wait_drain();
        check("mis_error", {31'd0, error}, 32'd1);
        check("mis_fail", {28'd0, fail_cnt}, 32'd1);
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        check("ff_exp", {16'd0, ff_exp}, 32'h1234);
        check("ff_got", {16'd0, ff_got}, 32'h1235);
        check("ff_idx", {28'd0, ff_idx}, 32'd0);
`endif

        // Asynchronous reset mid-run, between edges
        do_push(16'd1);
        do_push(16'd2);
        do_push(16'd3);
        check("pre_rst_level", {28'd0, level}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_level", {28'd0, level}, 32'd0);
        check("arst_ready", {31'd0, exp_ready}, 32'd1);
        check("arst_outputs", {23'd0, compare, correct, pass_cnt, fail_cnt, error, overflow, underflow},
              32'd0);
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        check("arst_ff_exp", {16'd0, ff_exp}, 32'd0);
`endif
        #2 rst = 1'b0;
        m_pass = 0;
        m_fail = 0;
        @(posedge clk); #1;

        // Full / overflow
        for (int i = 0; i < 8; i++) do_push(16'(10 + i));
        check("full_level", {28'd0, level}, 32'd8);
        check("full_ready", {31'd0, exp_ready}, 32'd0);
        do_push(16'd99);
        check("ovf_level", {28'd0, level}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        do_push_pop(16'd100, 16'd10, 1'b1);
        check("pp_level", {28'd0, level}, 32'd8);
        check("pp_ready", {31'd0, exp_ready}, 32'd0);
        for (int i = 1; i < 8; i++) do_dut(16'(10 + i), 1'b1);
        do_dut(16'd100, 1'b1);
        wait_drain();
        check("drain_level", {28'd0, level}, 32'd0);
        check("ovf_no_error", {31'd0, error}, 32'd0);
        check("ovf_pass", {28'd0, pass_cnt}, 32'd9);
        do_clear();

        // Underflow
        do_dut(16'd7, 1'b0);
        wait_drain();
        check("udf_flag", {31'd0, underflow}, 32'd1);
        check("udf_error", {31'd0, error}, 32'd1);
        check("udf_level", {28'd0, level}, 32'd0);
`ifdef CHK_FIRST_FAIL_CAPTURE_EN
        check("udf_ff_exp", {16'd0, ff_exp}, 32'd0);
        check("udf_ff_got", {16'd0, ff_got}, 32'd7);
        check("udf_ff_idx", {28'd0, ff_idx}, 32'd0);
`endif
        do_clear();
        check("clr_outputs", {23'd0, compare, correct, pass_cnt, fail_cnt, error, overflow, underflow},
              32'd0);

        // Saturation
        for (int i = 0; i < 20; i++) begin
            do_push(16'(i * 3 + 1));
            do_dut(16'(i * 3 + 1), 1'b1);
        end
        wait_drain();
        check("sat_pass", {28'd0, pass_cnt}, 32'd15);
        do_clear();
        check("sat_clr", {23'd0, compare, correct, pass_cnt, fail_cnt, error, overflow, underflow},
              32'd0);
        check("total_cmps", n_cmp, n_issued);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
